// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the 32-bit ALU. It resolves EX/MEM/WB bypassing at capture time,
// inserts load-use bubbles and keeps a saturating bubble count.
module id_ex_operand_stage #(
    parameter int unsigned N_BITS    = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [3:0]           id_alu_operation,
    input  logic [N_BITS-1:0]    id_rs_data,
    input  logic [N_BITS-1:0]    id_rt_data,
    input  logic [N_BITS-1:0]    id_imm,
    input  logic [4:0]           id_shamt,
    input  logic [4:0]           id_rs_addr,
    input  logic [4:0]           id_rt_addr,
    input  logic [4:0]           id_rd_addr,
    input  logic                 id_alu_src,
    input  logic                 id_reg_dst,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_mem_to_reg,
    input  logic [N_BITS-1:0]    alu_result,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_write_reg,
    input  logic [N_BITS-1:0]    mem_fwd_data,
    input  logic                 wb_reg_write,
    input  logic [4:0]           wb_write_reg,
    input  logic [N_BITS-1:0]    wb_data,
    input  logic                 stall_in,
    input  logic                 flush,
    output logic                 stall_id,
    output logic                 ex_valid,
    output logic [3:0]           ex_alu_operation,
    output logic [N_BITS-1:0]    ex_a,
    output logic [N_BITS-1:0]    ex_b,
    output logic [4:0]           ex_shamt,
    output logic [N_BITS-1:0]    ex_store_data,
    output logic [4:0]           ex_write_reg,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_mem_to_reg,
    output logic [CNT_WIDTH-1:0] bubble_count
);

    logic              ex_fwd_ok;
    logic              rs_ex_hit, rs_mem_hit, rs_wb_hit;
    logic              rt_ex_hit, rt_mem_hit, rt_wb_hit;
    logic              rt_used;
    logic              hazard;
    logic [N_BITS-1:0] fwd_rs, fwd_rt;
    logic [N_BITS-1:0] b_sel;
    logic [4:0]        write_reg_sel;

    // A load in EX has no result yet, so it never forwards from alu_result.
    assign ex_fwd_ok  = ex_valid & ex_reg_write & ~ex_mem_read;

    assign rs_ex_hit  = ex_fwd_ok && (ex_write_reg == id_rs_addr) && (id_rs_addr != 5'd0);
    assign rs_mem_hit = mem_reg_write && (mem_write_reg == id_rs_addr) && (id_rs_addr != 5'd0);
    assign rs_wb_hit  = wb_reg_write && (wb_write_reg == id_rs_addr) && (id_rs_addr != 5'd0);
    assign rt_ex_hit  = ex_fwd_ok && (ex_write_reg == id_rt_addr) && (id_rt_addr != 5'd0);
    assign rt_mem_hit = mem_reg_write && (mem_write_reg == id_rt_addr) && (id_rt_addr != 5'd0);
    assign rt_wb_hit  = wb_reg_write && (wb_write_reg == id_rt_addr) && (id_rt_addr != 5'd0);

    always_comb begin
        fwd_rs = id_rs_data;
        if (rs_ex_hit) begin
            fwd_rs = alu_result;
        end else if (rs_mem_hit) begin
            fwd_rs = mem_fwd_data;
        end else if (rs_wb_hit) begin
            fwd_rs = wb_data;
        end
    end

    always_comb begin
        fwd_rt = id_rt_data;
        if (rt_ex_hit) begin
            fwd_rt = alu_result;
        end else if (rt_mem_hit) begin
            fwd_rt = mem_fwd_data;
        end else if (rt_wb_hit) begin
            fwd_rt = wb_data;
        end
    end

    assign b_sel         = id_alu_src ? id_imm : fwd_rt;
    assign write_reg_sel = id_reg_dst ? id_rd_addr : id_rt_addr;

    // rt only matters when it feeds the ALU or is the store data.
    assign rt_used  = ~id_alu_src | id_mem_write;
    assign hazard   = id_valid & ex_valid & ex_mem_read & ex_reg_write & (ex_write_reg != 5'd0)
                    & ((ex_write_reg == id_rs_addr) | ((ex_write_reg == id_rt_addr) & rt_used));
    assign stall_id = stall_in | hazard;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid         <= 1'b0;
            ex_alu_operation <= 4'd0;
            ex_a             <= '0;
            ex_b             <= '0;
            ex_shamt         <= 5'd0;
            ex_store_data    <= '0;
            ex_write_reg     <= 5'd0;
            ex_reg_write     <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_mem_to_reg    <= 1'b0;
            bubble_count     <= '0;
        end else if (flush || !stall_in) begin
            if (flush || hazard) begin
                ex_valid         <= 1'b0;
                ex_alu_operation <= 4'd0;
                ex_a             <= '0;
                ex_b             <= '0;
                ex_shamt         <= 5'd0;
                ex_store_data    <= '0;
                ex_write_reg     <= 5'd0;
                ex_reg_write     <= 1'b0;
                ex_mem_read      <= 1'b0;
                ex_mem_write     <= 1'b0;
                ex_mem_to_reg    <= 1'b0;
            end else begin
                ex_valid         <= id_valid;
                ex_alu_operation <= id_alu_operation;
                ex_a             <= fwd_rs;
                ex_b             <= b_sel;
                ex_shamt         <= id_shamt;
                ex_store_data    <= fwd_rt;
                ex_write_reg     <= write_reg_sel;
                ex_reg_write     <= id_reg_write & id_valid;
                ex_mem_read      <= id_mem_read & id_valid;
                ex_mem_write     <= id_mem_write & id_valid;
                ex_mem_to_reg    <= id_mem_to_reg & id_valid;
            end
            // A flush swallows the hazard, so that case is not counted as a bubble.
            if (!flush && hazard && (bubble_count != {CNT_WIDTH{1'b1}})) begin
                bubble_count <= bubble_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: a vector table for capture/forwarding plus hand-written
// sequences for load-use, flush/stall, async reset and counter saturation.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_alu_operation;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs_addr, id_rt_addr, id_rd_addr;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [31:0] alu_result, mem_fwd_data, wb_data;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_write_reg, wb_write_reg;
    logic        stall_in, flush;

    logic        stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [3:0]  ex_alu_operation;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_shamt, ex_write_reg;
    logic [15:0] bubble_count;

    logic        stall_id_s, ex_valid_s, ex_reg_write_s, ex_mem_read_s, ex_mem_write_s;
    logic        ex_mem_to_reg_s;
    logic [3:0]  ex_alu_operation_s;
    logic [31:0] ex_a_s, ex_b_s, ex_store_data_s;
    logic [4:0]  ex_shamt_s, ex_write_reg_s;
    logic [1:0]  bubble_count_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.N_BITS(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_operation(id_alu_operation),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .alu_result(alu_result), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .mem_fwd_data(mem_fwd_data), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_data(wb_data), .stall_in(stall_in), .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_alu_operation(ex_alu_operation), .ex_a(ex_a), .ex_b(ex_b),
        .ex_shamt(ex_shamt), .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .bubble_count(bubble_count)
    );

    // Narrow-counter copy on the same stimulus, used for the saturation check.
    id_ex_operand_stage #(.N_BITS(32), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_operation(id_alu_operation),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .alu_result(alu_result), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .mem_fwd_data(mem_fwd_data), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_data(wb_data), .stall_in(stall_in), .flush(flush), .stall_id(stall_id_s),
        .ex_valid(ex_valid_s), .ex_alu_operation(ex_alu_operation_s), .ex_a(ex_a_s),
        .ex_b(ex_b_s), .ex_shamt(ex_shamt_s), .ex_store_data(ex_store_data_s),
        .ex_write_reg(ex_write_reg_s), .ex_reg_write(ex_reg_write_s),
        .ex_mem_read(ex_mem_read_s), .ex_mem_write(ex_mem_write_s),
        .ex_mem_to_reg(ex_mem_to_reg_s), .bubble_count(bubble_count_s)
    );

    typedef struct {
        logic [31:0] v, op, rs, rt, rd, src, dst, rw, mr, mw;
        logic [31:0] rsd, rtd, imm;
        logic [31:0] alu, mrw, mwr, mdata, wrw, wwr, wdata;
        logic [31:0] ev, ea, eb, es, ewr, erw, emr, emw;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_alu_operation = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_shamt = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_alu_src = 0;
        id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        alu_result = 0; mem_reg_write = 0; mem_write_reg = 0; mem_fwd_data = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_data = 0; stall_in = 0; flush = 0;
    endtask

    task automatic present_load9();
        clear_inputs();
        id_valid = 1; id_alu_operation = 4'd3; id_rs_addr = 5'd1; id_rt_addr = 5'd9;
        id_alu_src = 1; id_imm = 32'd4; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    endtask

    initial begin
        //            v op rs rt rd src dst rw mr mw  rsd      rtd      imm
        //            alu      mrw mwr mdata  wrw wwr wdata   ev ea      eb       es       ewr erw emr emw
        vt[0] = '{1, 3, 1, 2, 3, 0, 1, 1, 0, 0, 5, 7, 0,
                  0, 0, 0, 0, 0, 0, 0, 1, 5, 7, 7, 3, 1, 0, 0};
        vt[1] = '{1, 3, 4, 5, 8, 0, 1, 1, 0, 0, 'h11, 'h22, 0,
                  'h99, 1, 4, 'h44, 1, 5, 'h55, 1, 'h44, 'h55, 'h55, 8, 1, 0, 0};
        vt[2] = '{1, 3, 8, 8, 9, 1, 0, 1, 0, 0, 'h88, 'h89, 'h1234,
                  'h10, 1, 8, 'h20, 1, 8, 'h30, 1, 'h10, 'h1234, 'h10, 8, 1, 0, 0};
        vt[3] = '{1, 3, 0, 0, 0, 0, 1, 1, 0, 0, 'hAAAA, 'hBBBB, 0,
                  'hDEAD, 1, 0, 'h1, 1, 0, 'h2, 1, 'hAAAA, 'hBBBB, 'hBBBB, 0, 1, 0, 0};
        vt[4] = '{1, 3, 0, 6, 0, 0, 0, 0, 0, 1, 1, 2, 0,
                  'hDEAD, 1, 6, 'h66, 1, 6, 'h77, 1, 1, 'h66, 'h66, 6, 0, 0, 1};
        vt[5] = '{0, 3, 6, 6, 0, 0, 0, 1, 1, 0, 3, 4, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 4, 6, 0, 0, 0};
        vt[6] = '{1, 3, 7, 9, 10, 0, 1, 1, 0, 0, 1, 2, 0,
                  5, 0, 0, 0, 1, 7, 'h700, 1, 'h700, 2, 2, 10, 1, 0, 0};

        clear_inputs();
        reset = 1;
        #2 reset = 0;
        #1;
        check("reset_ex_valid", {31'd0, ex_valid}, 0);
        check("reset_ex_a", ex_a, 0);
        check("reset_count", {16'd0, bubble_count}, 0);
        check("reset_stall_id", {31'd0, stall_id}, 0);
        repeat (2) @(negedge clk);
        reset = 1;

        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            id_valid = vt[i].v[0]; id_alu_operation = vt[i].op[3:0];
            id_rs_addr = vt[i].rs[4:0]; id_rt_addr = vt[i].rt[4:0]; id_rd_addr = vt[i].rd[4:0];
            id_alu_src = vt[i].src[0]; id_reg_dst = vt[i].dst[0]; id_reg_write = vt[i].rw[0];
            id_mem_read = vt[i].mr[0]; id_mem_to_reg = vt[i].mr[0]; id_mem_write = vt[i].mw[0];
            id_rs_data = vt[i].rsd; id_rt_data = vt[i].rtd; id_imm = vt[i].imm;
            id_shamt = 5'(i + 1);
            alu_result = vt[i].alu; mem_reg_write = vt[i].mrw[0]; mem_write_reg = vt[i].mwr[4:0];
            mem_fwd_data = vt[i].mdata; wb_reg_write = vt[i].wrw[0];
            wb_write_reg = vt[i].wwr[4:0]; wb_data = vt[i].wdata;
            step();
            check($sformatf("v%0d_valid", i), {31'd0, ex_valid}, vt[i].ev);
            check($sformatf("v%0d_a", i), ex_a, vt[i].ea);
            check($sformatf("v%0d_b", i), ex_b, vt[i].eb);
            check($sformatf("v%0d_store", i), ex_store_data, vt[i].es);
            check($sformatf("v%0d_wreg", i), {27'd0, ex_write_reg}, vt[i].ewr);
            check($sformatf("v%0d_regwr", i), {31'd0, ex_reg_write}, vt[i].erw);
            check($sformatf("v%0d_memrd", i), {31'd0, ex_mem_read}, vt[i].emr);
            check($sformatf("v%0d_memtoreg", i), {31'd0, ex_mem_to_reg}, vt[i].emr);
            check($sformatf("v%0d_memwr", i), {31'd0, ex_mem_write}, vt[i].emw);
            if (vt[i].v[0]) begin
                check($sformatf("v%0d_op", i), {28'd0, ex_alu_operation}, vt[i].op);
                check($sformatf("v%0d_shamt", i), {27'd0, ex_shamt}, i + 1);
            end
        end

        // Load-use on rt: one bubble, then MEM forwarding on re-presentation.
        present_load9();
        step();
        check("lw_in_ex", {31'd0, ex_mem_read}, 1);
        clear_inputs();
        id_valid = 1; id_rs_addr = 2; id_rt_addr = 9; id_rt_data = 32'h1111;
        id_reg_dst = 1; id_rd_addr = 10; id_reg_write = 1;
        #1;
        check("hazard_stall_id", {31'd0, stall_id}, 1);
        step();
        check("hazard_bubble_valid", {31'd0, ex_valid}, 0);
        check("hazard_count", {16'd0, bubble_count}, 1);
        check("hazard_stall_clear", {31'd0, stall_id}, 0);
        mem_reg_write = 1; mem_write_reg = 9; mem_fwd_data = 32'hABCD;
        step();
        check("replay_valid", {31'd0, ex_valid}, 1);
        check("replay_b_mem_fwd", ex_b, 32'hABCD);
        check("replay_store", ex_store_data, 32'hABCD);

        // rt only as immediate-form source: no hazard.
        present_load9();
        step();
        clear_inputs();
        id_valid = 1; id_rs_addr = 2; id_rt_addr = 9; id_alu_src = 1; id_imm = 32'd8;
        id_reg_write = 1;
        #1;
        check("imm_no_stall", {31'd0, stall_id}, 0);
        step();
        check("imm_valid", {31'd0, ex_valid}, 1);
        check("imm_b", ex_b, 32'd8);
        check("imm_count", {16'd0, bubble_count}, 1);

        // Store data needs rt even with alu_src=1.
        present_load9();
        step();
        clear_inputs();
        id_valid = 1; id_rs_addr = 2; id_rt_addr = 9; id_alu_src = 1; id_mem_write = 1;
        #1;
        check("store_stall", {31'd0, stall_id}, 1);
        step();
        check("store_count", {16'd0, bubble_count}, 2);

        // Flush together with hazard: bubble without counting.
        present_load9();
        step();
        clear_inputs();
        id_valid = 1; id_rs_addr = 9; id_reg_write = 1; flush = 1;
        #1;
        check("flush_hz_stall", {31'd0, stall_id}, 1);
        step();
        check("flush_hz_valid", {31'd0, ex_valid}, 0);
        check("flush_hz_count", {16'd0, bubble_count}, 2);

        // Flush beats stall_in.
        clear_inputs();
        id_valid = 1; id_rs_addr = 1; id_reg_write = 1;
        step();
        check("pre_flush_valid", {31'd0, ex_valid}, 1);
        flush = 1; stall_in = 1;
        step();
        check("flush_stall_valid", {31'd0, ex_valid}, 0);
        check("flush_stall_regwr", {31'd0, ex_reg_write}, 0);

        // stall_in holds EX for three cycles.
        clear_inputs();
        id_valid = 1; id_alu_operation = 4'd3; id_rs_addr = 1; id_rt_addr = 2;
        id_rs_data = 32'h123; id_rt_data = 32'h456; id_reg_dst = 1; id_rd_addr = 7;
        id_reg_write = 1;
        step();
        stall_in = 1; id_rs_data = 32'hFFFF; id_rt_data = 32'hEEEE; id_rd_addr = 12;
        #1;
        check("stall_in_stall_id", {31'd0, stall_id}, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("hold%0d_a", k), ex_a, 32'h123);
            check($sformatf("hold%0d_b", k), ex_b, 32'h456);
            check($sformatf("hold%0d_wreg", k), {27'd0, ex_write_reg}, 7);
            check($sformatf("hold%0d_valid", k), {31'd0, ex_valid}, 1);
        end
        stall_in = 0;
        step();
        check("resume_a", ex_a, 32'hFFFF);
        check("resume_wreg", {27'd0, ex_write_reg}, 12);

        // Asynchronous reset mid-stall.
        stall_in = 1;
        #3 reset = 0;
        #1;
        check("async_valid", {31'd0, ex_valid}, 0);
        check("async_a", ex_a, 0);
        check("async_b", ex_b, 0);
        check("async_wreg", {27'd0, ex_write_reg}, 0);
        check("async_regwr", {31'd0, ex_reg_write}, 0);
        check("async_count", {16'd0, bubble_count}, 0);
        check("async_count_sat", {30'd0, bubble_count_s}, 0);
        check("async_stall_id", {31'd0, stall_id}, 1);
        stall_in = 0;
        #1;
        check("async_stall_id_free", {31'd0, stall_id}, 0);
        @(negedge clk);
        reset = 1;
        clear_inputs();
        step();

        // Five load-use hazards against a 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            present_load9();
            step();
            clear_inputs();
            id_valid = 1; id_rs_addr = 9; id_reg_write = 1;
            step();
            check($sformatf("sat%0d", k), {30'd0, bubble_count_s}, (k + 1 > 3) ? 3 : k + 1);
            check($sformatf("wide%0d", k), {16'd0, bubble_count}, k + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
